// File: rtl/mem_req_arbiter_pkg.sv
// Shared types for the memory request arbiter: state encodings, op codes,
// bus field types and the captured controller command.
package mem_req_arbiter_pkg;

  localparam logic OP_LD = 1'b0;
  localparam logic OP_ST = 1'b1;

  typedef logic [2:0]  LEN_TYPE;
  typedef logic [31:0] ADDR_TYPE;
  typedef logic [31:0] DATA_TYPE;

  localparam logic [1:0] IO_REGION = 2'b11;

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_BUSY_IF = 3'd1,
    ARB_BUSY_LD = 3'd2,
    ARB_BUSY_ST = 3'd3,
    ARB_DRAIN   = 3'd4,
    ARB_GAP     = 3'd5
  } arb_state_e;

  typedef enum logic [1:0] {GNT_NONE, GNT_IF, GNT_LD, GNT_ST} gnt_e;

  typedef struct packed {
    logic     op;
    logic     is_if;
    LEN_TYPE  len;
    ADDR_TYPE addr;
    DATA_TYPE data;
  } mc_cmd_t;

  // Controller returns the raw word; trim to the requested byte count.
  function automatic DATA_TYPE zext_len(input DATA_TYPE d, input LEN_TYPE len);
    case (len)
      3'd1:    return {24'd0, d[7:0]};
      3'd2:    return {16'd0, d[15:0]};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_req_arbiter_sel.sv
// Combinational grant select for IDLE arbitration: store, starved fetch,
// load, fetch. A store to the IO region is skipped while the UART buffer is full.
module arb_priority_sel
  import mem_req_arbiter_pkg::*;
#(
  parameter logic [1:0] IO_ADDR_HI = IO_REGION
) (
  input  logic       if_req_i,
  input  logic       lsb_req_i,
  input  logic       lsb_op_i,
  input  logic [1:0] lsb_addr_hi_i,
  input  logic       io_buffer_full_i,
  input  logic       starved_i,
  output gnt_e       gnt_o
);

  logic io_blocked;
  assign io_blocked = (lsb_addr_hi_i == IO_ADDR_HI) && io_buffer_full_i;

  always_comb begin
    gnt_o = GNT_NONE;
    if (lsb_req_i && lsb_op_i == OP_ST && !io_blocked) gnt_o = GNT_ST;
    else if (if_req_i && starved_i)                     gnt_o = GNT_IF;
    else if (lsb_req_i && lsb_op_i == OP_LD)            gnt_o = GNT_LD;
    else if (if_req_i)                                  gnt_o = GNT_IF;
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Owns the memory controller request port: arbitrates fetch vs load/store,
// holds the granted command until done, and routes completions back.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int         STARVE_LIMIT = 8,
  parameter logic [1:0] IO_ADDR_HI   = IO_REGION
) (
  input  logic     clk_in,
  input  logic     rstn_in,
  input  logic     rdy_in,
  input  logic     clr_in,
  input  logic     io_buffer_full,
  input  logic     if_req,
  input  ADDR_TYPE if_addr,
  output logic     if_done,
  output DATA_TYPE if_inst,
  input  logic     lsb_req,
  input  logic     lsb_op,
  input  LEN_TYPE  lsb_len,
  input  ADDR_TYPE lsb_addr,
  input  DATA_TYPE lsb_data,
  output logic     lsb_ld_done,
  output logic     lsb_st_done,
  output DATA_TYPE lsb_result,
  output logic     mc_req,
  output logic     mc_op,
  output logic     mc_is_if,
  output LEN_TYPE  mc_len,
  output ADDR_TYPE mc_addr,
  output DATA_TYPE mc_data,
  input  logic     mc_if_ready,
  input  DATA_TYPE mc_if_inst,
  input  logic     mc_ld_done,
  input  logic     mc_st_done,
  input  DATA_TYPE mc_result
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_e    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  mc_cmd_t       cmd_q, cmd_d;
  logic          mc_req_q, mc_req_d;
  logic          clr_pend_q, clr_pend_d;
  logic          if_done_q, if_done_d, ld_done_q, ld_done_d, st_done_q, st_done_d;
  DATA_TYPE      if_inst_q, if_inst_d, result_q, result_d;
  gnt_e          gnt;
  logic          starved;

  assign starved = (starve_q >= SW'(STARVE_LIMIT));

  arb_priority_sel #(.IO_ADDR_HI(IO_ADDR_HI)) u_sel (
    .if_req_i        (if_req),
    .lsb_req_i       (lsb_req),
    .lsb_op_i        (lsb_op),
    .lsb_addr_hi_i   (lsb_addr[17:16]),
    .io_buffer_full_i(io_buffer_full),
    .starved_i       (starved),
    .gnt_o           (gnt)
  );

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    cmd_d      = cmd_q;
    mc_req_d   = mc_req_q;
    clr_pend_d = clr_pend_q;
    if_done_d  = if_done_q;
    ld_done_d  = ld_done_q;
    st_done_d  = st_done_q;
    if_inst_d  = if_inst_q;
    result_d   = result_q;
    if (rdy_in) begin
      if_done_d = 1'b0;
      ld_done_d = 1'b0;
      st_done_d = 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (clr_in) begin
            starve_d = '0;
          end else begin
            if (!if_req || gnt == GNT_IF) starve_d = '0;
            else if (!starved)            starve_d = starve_q + 1'b1;
            case (gnt)
              GNT_IF: begin
                cmd_d.op = OP_LD; cmd_d.is_if = 1'b1; cmd_d.len = 3'd4;
                cmd_d.addr = if_addr; cmd_d.data = '0;
                mc_req_d = 1'b1; state_d = ARB_BUSY_IF;
              end
              GNT_LD, GNT_ST: begin
                cmd_d.op = (gnt == GNT_ST) ? OP_ST : OP_LD; cmd_d.is_if = 1'b0;
                cmd_d.len = lsb_len; cmd_d.addr = lsb_addr; cmd_d.data = lsb_data;
                mc_req_d = 1'b1;
                state_d  = (gnt == GNT_ST) ? ARB_BUSY_ST : ARB_BUSY_LD;
              end
              default: ;
            endcase
          end
        end
        ARB_BUSY_IF: begin
          if (clr_in) begin
            mc_req_d = 1'b0; state_d = ARB_GAP;
          end else if (mc_if_ready) begin
            mc_req_d = 1'b0; state_d = ARB_GAP;
            if_done_d = 1'b1; if_inst_d = mc_if_inst;
          end
        end
        // A flushed load still owns the controller until it finishes.
        ARB_BUSY_LD: begin
          if (mc_ld_done) begin
            mc_req_d = 1'b0; clr_pend_d = 1'b0;
            if (clr_in || clr_pend_q) begin
              state_d = ARB_DRAIN;
            end else begin
              state_d = ARB_GAP; ld_done_d = 1'b1;
              result_d = zext_len(mc_result, cmd_q.len);
            end
          end else if (clr_in) begin
            clr_pend_d = 1'b1;
          end
        end
        ARB_BUSY_ST: begin
          if (mc_st_done) begin
            mc_req_d = 1'b0; state_d = ARB_GAP; st_done_d = 1'b1;
          end
        end
        ARB_DRAIN: state_d = ARB_IDLE;
        ARB_GAP: begin
          state_d = ARB_IDLE;
          if (clr_in) starve_d = '0;
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state_q    <= ARB_IDLE;
      starve_q   <= '0;
      cmd_q      <= '0;
      mc_req_q   <= 1'b0;
      clr_pend_q <= 1'b0;
      if_done_q  <= 1'b0;
      ld_done_q  <= 1'b0;
      st_done_q  <= 1'b0;
      if_inst_q  <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      cmd_q      <= cmd_d;
      mc_req_q   <= mc_req_d;
      clr_pend_q <= clr_pend_d;
      if_done_q  <= if_done_d;
      ld_done_q  <= ld_done_d;
      st_done_q  <= st_done_d;
      if_inst_q  <= if_inst_d;
      result_q   <= result_d;
    end
  end

  assign mc_req      = mc_req_q;
  assign mc_op       = cmd_q.op;
  assign mc_is_if    = cmd_q.is_if;
  assign mc_len      = cmd_q.len;
  assign mc_addr     = cmd_q.addr;
  assign mc_data     = cmd_q.data;
  assign if_done     = if_done_q;
  assign if_inst     = if_inst_q;
  assign lsb_ld_done = ld_done_q;
  assign lsb_st_done = st_done_q;
  assign lsb_result  = result_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scenario bench for mem_req_arbiter plus randomized traffic against a
// transaction-level arbitration/completion model.
module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;

  logic     clk, rstn, rdy, clr, io_full;
  logic     if_req;   ADDR_TYPE if_addr;
  logic     if_done;  DATA_TYPE if_inst;
  logic     lsb_req, lsb_op; LEN_TYPE lsb_len; ADDR_TYPE lsb_addr; DATA_TYPE lsb_data;
  logic     lsb_ld_done, lsb_st_done; DATA_TYPE lsb_result;
  logic     mc_req, mc_op, mc_is_if; LEN_TYPE mc_len; ADDR_TYPE mc_addr; DATA_TYPE mc_data;
  logic     mc_if_ready, mc_ld_done, mc_st_done;
  DATA_TYPE mc_if_inst, mc_result;

  int errors = 0;
  int checks = 0;

  mem_req_arbiter dut (
    .clk_in(clk), .rstn_in(rstn), .rdy_in(rdy), .clr_in(clr), .io_buffer_full(io_full),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
    .lsb_req(lsb_req), .lsb_op(lsb_op), .lsb_len(lsb_len), .lsb_addr(lsb_addr),
    .lsb_data(lsb_data), .lsb_ld_done(lsb_ld_done), .lsb_st_done(lsb_st_done),
    .lsb_result(lsb_result), .mc_req(mc_req), .mc_op(mc_op), .mc_is_if(mc_is_if),
    .mc_len(mc_len), .mc_addr(mc_addr), .mc_data(mc_data), .mc_if_ready(mc_if_ready),
    .mc_if_inst(mc_if_inst), .mc_ld_done(mc_ld_done), .mc_st_done(mc_st_done),
    .mc_result(mc_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic DATA_TYPE mem_word(input ADDR_TYPE a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic DATA_TYPE ld_ext(input DATA_TYPE d, input LEN_TYPE n);
    DATA_TYPE m;
    m = (n >= 3'd4) ? 32'hFFFF_FFFF : ((32'd1 << (32'd8 * 32'(n))) - 32'd1);
    return d & m;
  endfunction

  task automatic idle_inputs;
    rdy = 1'b1; clr = 1'b0; io_full = 1'b0;
    if_req = 1'b0; if_addr = '0;
    lsb_req = 1'b0; lsb_op = OP_LD; lsb_len = 3'd4; lsb_addr = '0; lsb_data = '0;
    mc_if_ready = 1'b0; mc_ld_done = 1'b0; mc_st_done = 1'b0;
    mc_if_inst = '0; mc_result = '0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    idle_inputs();
    rstn = 1'b0;
    cyc(2);
    rstn = 1'b1;
    cyc(1);
  endtask

  task automatic test_reset;
    idle_inputs();
    rstn = 1'b0;
    cyc(2);
    checks++;
    if ({mc_req, mc_op, mc_is_if, mc_len, mc_addr, mc_data, if_done, if_inst,
         lsb_ld_done, lsb_st_done, lsb_result} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero output mc_req=%b mc_addr=%h", mc_req, mc_addr);
    end
    checks++;
    if (dut.state_q !== ARB_IDLE || dut.starve_q !== '0) begin
      errors++; $display("FAIL reset_state: state=%0d starve=%0d required 0/0", dut.state_q, dut.starve_q);
    end
    rstn = 1'b1;
    cyc(1);
  endtask

  task automatic test_fetch_only;
    logic held;
    if_req = 1'b1; if_addr = 32'h100;
    cyc(1);
    checks++;
    if ({mc_req, mc_is_if, mc_len, mc_addr} !== {1'b1, 1'b1, 3'd4, 32'h100}) begin
      errors++; $display("FAIL fo_grant: req=%b is_if=%b len=%0d addr=%h required 1/1/4/00000100",
                         mc_req, mc_is_if, mc_len, mc_addr);
    end
    held = 1'b1;
    repeat (5) begin cyc(1); if (mc_req !== 1'b1 || if_done !== 1'b0) held = 1'b0; end
    checks++;
    if (!held) begin errors++; $display("FAIL fo_hold: mc_req dropped or early if_done, required held"); end
    mc_if_ready = 1'b1; mc_if_inst = 32'hDEADBEEF;
    cyc(1);
    mc_if_ready = 1'b0; mc_if_inst = '0; if_req = 1'b0;
    checks++;
    if ({mc_req, if_done, if_inst} !== {1'b0, 1'b1, 32'hDEADBEEF}) begin
      errors++; $display("FAIL fo_done: req=%b if_done=%b inst=%h required 0/1/deadbeef", mc_req, if_done, if_inst);
    end
    cyc(1);
    checks++;
    if ({mc_req, if_done} !== 2'b00) begin
      errors++; $display("FAIL fo_gap: req=%b if_done=%b required 0/0", mc_req, if_done);
    end
    cyc(1);
  endtask

  task automatic test_store_vs_fetch;
    lsb_req = 1'b1; lsb_op = OP_ST; lsb_len = 3'd4; lsb_addr = 32'h2000; lsb_data = 32'h1234_5678;
    if_req = 1'b1; if_addr = 32'h200;
    cyc(1);
    checks++;
    if ({mc_req, mc_is_if, mc_op, mc_addr, mc_data} !== {1'b1, 1'b0, OP_ST, 32'h2000, 32'h1234_5678}) begin
      errors++; $display("FAIL sf_store_first: req=%b is_if=%b op=%b addr=%h data=%h required store 2000",
                         mc_req, mc_is_if, mc_op, mc_addr, mc_data);
    end
    cyc(2);
    mc_st_done = 1'b1;
    cyc(1);
    mc_st_done = 1'b0; lsb_req = 1'b0;
    checks++;
    if ({mc_req, lsb_st_done} !== 2'b01) begin
      errors++; $display("FAIL sf_st_done: req=%b st_done=%b required 0/1", mc_req, lsb_st_done);
    end
    cyc(1);
    checks++;
    if ({mc_req, lsb_st_done} !== 2'b00) begin
      errors++; $display("FAIL sf_idle: req=%b st_done=%b required 0/0", mc_req, lsb_st_done);
    end
    cyc(1);
    checks++;
    if ({mc_req, mc_is_if, mc_addr} !== {1'b1, 1'b1, 32'h200}) begin
      errors++; $display("FAIL sf_fetch_second: req=%b is_if=%b addr=%h required 1/1/00000200", mc_req, mc_is_if, mc_addr);
    end
    mc_if_ready = 1'b1; mc_if_inst = 32'h0BAD_F00D;
    cyc(1);
    mc_if_ready = 1'b0; if_req = 1'b0;
    checks++;
    if ({if_done, if_inst} !== {1'b1, 32'h0BAD_F00D}) begin
      errors++; $display("FAIL sf_if_done: if_done=%b inst=%h required 1/0badf00d", if_done, if_inst);
    end
    cyc(2);
  endtask

  task automatic test_io_store;
    io_full = 1'b1;
    lsb_req = 1'b1; lsb_op = OP_ST; lsb_len = 3'd1; lsb_addr = 32'h30000; lsb_data = 32'h41;
    cyc(4);
    checks++;
    if (mc_req !== 1'b0) begin errors++; $display("FAIL io_blocked: mc_req=%b required 0", mc_req); end
    if_req = 1'b1; if_addr = 32'h600;
    cyc(1);
    checks++;
    if ({mc_req, mc_is_if, mc_addr} !== {1'b1, 1'b1, 32'h600}) begin
      errors++; $display("FAIL io_fetch_past_store: req=%b is_if=%b addr=%h required fetch 600", mc_req, mc_is_if, mc_addr);
    end
    io_full = 1'b0;
    cyc(2);
    mc_if_ready = 1'b1; mc_if_inst = 32'h1;
    cyc(1);
    mc_if_ready = 1'b0; if_req = 1'b0;
    cyc(2);
    checks++;
    if ({mc_req, mc_is_if, mc_op, mc_addr, mc_data} !== {1'b1, 1'b0, OP_ST, 32'h30000, 32'h41}) begin
      errors++; $display("FAIL io_store_granted: req=%b is_if=%b op=%b addr=%h required store 30000",
                         mc_req, mc_is_if, mc_op, mc_addr);
    end
    io_full = 1'b1;
    cyc(2);
    checks++;
    if ({mc_req, mc_addr} !== {1'b1, 32'h30000}) begin
      errors++; $display("FAIL io_inflight: req=%b addr=%h required 1/00030000", mc_req, mc_addr);
    end
    mc_st_done = 1'b1;
    cyc(1);
    mc_st_done = 1'b0; lsb_req = 1'b0; io_full = 1'b0;
    checks++;
    if (lsb_st_done !== 1'b1) begin errors++; $display("FAIL io_st_done: st_done=%b required 1", lsb_st_done); end
    cyc(2);
  endtask

  task automatic test_starvation;
    int  loads;
    logic got_if, prev;
    loads = 0; got_if = 1'b0; prev = 1'b0;
    lsb_req = 1'b1; lsb_op = OP_LD; lsb_len = 3'd4; lsb_addr = 32'h700;
    if_req = 1'b1; if_addr = 32'h800;
    for (int c = 0; c < 300 && !got_if; c++) begin
      @(negedge clk);
      mc_ld_done = 1'b0;
      if (mc_req && !prev) begin
        if (mc_is_if) got_if = 1'b1; else loads++;
      end else if (mc_req && prev && !mc_is_if) begin
        mc_ld_done = 1'b1; mc_result = 32'h55;
      end
      prev = mc_req;
    end
    checks++;
    if (!got_if) begin errors++; $display("FAIL starve_timeout: fetch never granted, required a grant"); end
    checks++;
    if (loads != 8) begin errors++; $display("FAIL starve_loads: loads before fetch=%0d required 8", loads); end
    checks++;
    if (dut.starve_q !== '0) begin errors++; $display("FAIL starve_clear: starve_cnt=%0d required 0", dut.starve_q); end
    cyc(1);
    mc_if_ready = 1'b1; mc_if_inst = 32'h2;
    cyc(1);
    mc_if_ready = 1'b0; if_req = 1'b0; lsb_req = 1'b0;
    checks++;
    if (if_done !== 1'b1) begin errors++; $display("FAIL starve_if_done: if_done=%b required 1", if_done); end
    cyc(2);
  endtask

  task automatic test_clr;
    // Flush during a load: controller finishes, result discarded, DRAIN then IDLE.
    lsb_req = 1'b1; lsb_op = OP_LD; lsb_len = 3'd2; lsb_addr = 32'h400;
    cyc(1);
    clr = 1'b1; lsb_req = 1'b0;
    cyc(1);
    clr = 1'b0;
    cyc(2);
    checks++;
    if (mc_req !== 1'b1) begin errors++; $display("FAIL clr_ld_held: mc_req=%b required 1", mc_req); end
    mc_ld_done = 1'b1; mc_result = 32'hABCD;
    cyc(1);
    mc_ld_done = 1'b0;
    checks++;
    if ({mc_req, lsb_ld_done} !== 2'b00 || dut.state_q !== ARB_DRAIN) begin
      errors++; $display("FAIL clr_ld_drain: req=%b ld_done=%b state=%0d required 0/0/DRAIN", mc_req, lsb_ld_done, dut.state_q);
    end
    cyc(1);
    checks++;
    if (lsb_ld_done !== 1'b0 || dut.state_q !== ARB_IDLE) begin
      errors++; $display("FAIL clr_ld_idle: ld_done=%b state=%0d required 0/IDLE", lsb_ld_done, dut.state_q);
    end
    // Flush during a fetch: request drops on the next edge.
    if_req = 1'b1; if_addr = 32'h500;
    cyc(1);
    clr = 1'b1; if_req = 1'b0;
    cyc(1);
    clr = 1'b0;
    checks++;
    if ({mc_req, if_done} !== 2'b00) begin
      errors++; $display("FAIL clr_if: req=%b if_done=%b required 0/0", mc_req, if_done);
    end
    cyc(1);
    checks++;
    if (if_done !== 1'b0) begin errors++; $display("FAIL clr_if_nodone: if_done=%b required 0", if_done); end
    // Flush in IDLE blocks that cycle's grant.
    if_req = 1'b1; if_addr = 32'h540; clr = 1'b1;
    cyc(1);
    clr = 1'b0; if_req = 1'b0;
    checks++;
    if (mc_req !== 1'b0) begin errors++; $display("FAIL clr_idle: mc_req=%b required 0", mc_req); end
    cyc(1);
    // Flush coincident with load done suppresses it.
    lsb_req = 1'b1; lsb_op = OP_LD; lsb_len = 3'd4; lsb_addr = 32'h440;
    cyc(2);
    mc_ld_done = 1'b1; clr = 1'b1; lsb_req = 1'b0;
    cyc(1);
    mc_ld_done = 1'b0; clr = 1'b0;
    checks++;
    if ({mc_req, lsb_ld_done} !== 2'b00) begin
      errors++; $display("FAIL clr_ld_coinc: req=%b ld_done=%b required 0/0", mc_req, lsb_ld_done);
    end
    cyc(2);
    // Stores are committed regardless of flush.
    lsb_req = 1'b1; lsb_op = OP_ST; lsb_len = 3'd4; lsb_addr = 32'h900; lsb_data = 32'h9;
    cyc(2);
    mc_st_done = 1'b1; clr = 1'b1;
    cyc(1);
    mc_st_done = 1'b0; clr = 1'b0; lsb_req = 1'b0;
    checks++;
    if (lsb_st_done !== 1'b1) begin errors++; $display("FAIL clr_st: st_done=%b required 1", lsb_st_done); end
    cyc(2);
  endtask

  task automatic test_rdy_hold;
    logic ok;
    if_req = 1'b1; if_addr = 32'hB00;
    cyc(1);
    rdy = 1'b0; if_addr = 32'hC00;
    lsb_req = 1'b1; lsb_op = OP_ST; lsb_addr = 32'h40;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mc_if_ready = (i == 2);
      cyc(1);
      if (mc_req !== 1'b1 || mc_addr !== 32'hB00 || mc_is_if !== 1'b1 || if_done !== 1'b0 ||
          dut.state_q !== ARB_BUSY_IF || dut.starve_q !== '0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL rdy_freeze: state or outputs changed while rdy_in low (addr=%h)", mc_addr); end
    rdy = 1'b1; mc_if_ready = 1'b0; lsb_req = 1'b0;
    cyc(1);
    checks++;
    if (mc_req !== 1'b1) begin errors++; $display("FAIL rdy_resume: mc_req=%b required 1", mc_req); end
    mc_if_ready = 1'b1; mc_if_inst = 32'hCAFE;
    cyc(1);
    mc_if_ready = 1'b0; if_req = 1'b0;
    checks++;
    if ({if_done, if_inst} !== {1'b1, 32'hCAFE}) begin
      errors++; $display("FAIL rdy_done: if_done=%b inst=%h required 1/0000cafe", if_done, if_inst);
    end
    cyc(2);
  endtask

  task automatic test_reset_mid_store;
    lsb_req = 1'b1; lsb_op = OP_ST; lsb_len = 3'd4; lsb_addr = 32'hA00; lsb_data = 32'h77;
    cyc(1);
    checks++;
    if (mc_req !== 1'b1) begin errors++; $display("FAIL rst_pre: mc_req=%b required 1", mc_req); end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({mc_req, mc_op, mc_is_if, mc_len, mc_addr, mc_data, if_done, if_inst,
         lsb_ld_done, lsb_st_done, lsb_result} !== '0) begin
      errors++; $display("FAIL rst_async: outputs not cleared, mc_req=%b mc_addr=%h required 0", mc_req, mc_addr);
    end
    lsb_req = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    cyc(1);
  endtask

  task automatic test_random;
    int       exp_t, losses, last_done, if_cool, ls_cool, lat, grants, w;
    DATA_TYPE exp_d;
    logic     p_if, p_lsb, p_op, prev_req, mc_seen, mc_resp;
    ADDR_TYPE p_ia, p_la, c_addr, a;
    LEN_TYPE  p_len, c_len;
    DATA_TYPE p_dat, c_data;
    logic     c_if, c_op;
    logic [2:0] exp_v;
    do_reset();
    exp_t = 0; exp_d = '0; losses = 0; last_done = -10; if_cool = 0; ls_cool = 0; lat = 0; grants = 0;
    p_if = 0; p_lsb = 0; p_op = 0; prev_req = 0; mc_seen = 0; mc_resp = 0;
    p_ia = '0; p_la = '0; p_len = '0; p_dat = '0; c_addr = '0; c_len = '0; c_data = '0; c_if = 0; c_op = 0;
    for (int cy = 0; cy < 2000; cy++) begin
      @(negedge clk);
      mc_if_ready = 1'b0; mc_ld_done = 1'b0; mc_st_done = 1'b0;
      exp_v = (exp_t == 1) ? 3'b100 : (exp_t == 2) ? 3'b010 : (exp_t == 3) ? 3'b001 : 3'b000;
      checks++;
      if ({if_done, lsb_ld_done, lsb_st_done} !== exp_v) begin
        errors++; $display("FAIL rnd_done cy=%0d: got if/ld/st=%b required %b", cy, {if_done, lsb_ld_done, lsb_st_done}, exp_v);
      end
      if (exp_t == 1 || exp_t == 2) begin
        checks++;
        if ((exp_t == 1 ? if_inst : lsb_result) !== exp_d) begin
          errors++; $display("FAIL rnd_data cy=%0d: got %h required %h", cy, (exp_t == 1 ? if_inst : lsb_result), exp_d);
        end
      end
      exp_t = 0;
      if (mc_req && !prev_req) begin
        if (p_lsb && p_op == OP_ST)  w = 3;
        else if (p_if && losses >= 8) w = 1;
        else if (p_lsb)               w = 2;
        else if (p_if)                w = 1;
        else                          w = 0;
        losses = (!p_if || w == 1) ? 0 : ((losses < 8) ? losses + 1 : 8);
        grants++;
        checks++;
        if (w == 0) begin
          errors++; $display("FAIL rnd_grant cy=%0d: grant with no pending request", cy);
        end else if (w == 1 && {mc_is_if, mc_op, mc_len, mc_addr} !== {1'b1, OP_LD, 3'd4, p_ia}) begin
          errors++; $display("FAIL rnd_grant cy=%0d: got is_if=%b addr=%h required fetch %h", cy, mc_is_if, mc_addr, p_ia);
        end else if (w >= 2 && ({mc_is_if, mc_op, mc_len, mc_addr} !== {1'b0, (w == 3), p_len, p_la} ||
                                (w == 3 && mc_data !== p_dat))) begin
          errors++; $display("FAIL rnd_grant cy=%0d: got is_if=%b op=%b addr=%h required lsb op=%0d addr=%h",
                             cy, mc_is_if, mc_op, mc_addr, w == 3, p_la);
        end
        checks++;
        if (cy - last_done < 3) begin
          errors++; $display("FAIL rnd_spacing cy=%0d: grant %0d cycles after done required >=3", cy, cy - last_done);
        end
        c_if = mc_is_if; c_op = mc_op; c_len = mc_len; c_addr = mc_addr; c_data = mc_data;
      end else if (mc_req && prev_req) begin
        checks++;
        if ({mc_is_if, mc_op, mc_len, mc_addr, mc_data} !== {c_if, c_op, c_len, c_addr, c_data}) begin
          errors++; $display("FAIL rnd_stable cy=%0d: fields changed addr=%h required %h", cy, mc_addr, c_addr);
        end
      end
      if (!mc_req) begin
        mc_seen = 1'b0; mc_resp = 1'b0;
      end else if (!mc_seen) begin
        mc_seen = 1'b1; lat = $urandom_range(0, 3);
      end else if (!mc_resp) begin
        if (lat == 0) begin
          mc_resp = 1'b1; last_done = cy;
          if (c_if) begin
            mc_if_ready = 1'b1; mc_if_inst = mem_word(c_addr); exp_t = 1; exp_d = mem_word(c_addr);
          end else if (c_op == OP_ST) begin
            mc_st_done = 1'b1; exp_t = 3;
          end else begin
            mc_ld_done = 1'b1; mc_result = mem_word(c_addr); exp_t = 2; exp_d = ld_ext(mem_word(c_addr), c_len);
          end
        end else begin
          lat--;
          if ($urandom_range(0, 3) == 0) begin
            if (c_if) mc_ld_done = 1'b1; else mc_if_ready = 1'b1;
          end
        end
      end
      io_full = ($urandom_range(0, 1) == 1);
      if (if_done) begin if_req = 1'b0; if_cool = $urandom_range(1, 3); end
      else if (if_cool > 0) if_cool--;
      else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; a = $urandom; if_addr = a & 32'hFFFF_FFFC;
      end
      if (lsb_ld_done || lsb_st_done) begin lsb_req = 1'b0; ls_cool = $urandom_range(1, 3); end
      else if (ls_cool > 0) ls_cool--;
      else if (!lsb_req && $urandom_range(0, 1) == 0) begin
        lsb_req = 1'b1; lsb_op = $urandom_range(0, 1) == 1;
        case ($urandom_range(0, 2)) 0: lsb_len = 3'd1; 1: lsb_len = 3'd2; default: lsb_len = 3'd4; endcase
        a = $urandom; if (a[17:16] == IO_REGION) a[17:16] = 2'b00;
        lsb_addr = a; lsb_data = $urandom;
      end
      prev_req = mc_req;
      p_if = if_req; p_lsb = lsb_req; p_op = lsb_op; p_ia = if_addr;
      p_la = lsb_addr; p_len = lsb_len; p_dat = lsb_data;
    end
    checks++;
    if (grants < 100) begin errors++; $display("FAIL rnd_progress: grants=%0d required >=100", grants); end
    idle_inputs();
    cyc(4);
  endtask

  initial begin
    idle_inputs();
    rstn = 1'b0;
    test_reset();
    test_fetch_only();
    test_store_vs_fetch();
    test_io_store();
    test_starvation();
    test_clr();
    test_rdy_hold();
    test_reset_mid_store();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
